// File: rtl/iob_cache_axi_pkg.sv
// Shared AXI constants and state encoding for the cache-side AXI write path.
// Also intended for a future read-channel arbiter.
package iob_cache_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_AWCACHE    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// searching upward with wrap-around. Returns one-hot grant and binary index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && req_i[pos]) begin
        valid_o      = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI4 write master between N_REQ single-beat cache write channels,
// granting round-robin and replaying the captured beat on error responses.
module axi_write_arbiter
  import iob_cache_axi_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_ID    = 0,
  parameter int RETRY_MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           req_err,
  output logic [AXI_ID_W-1:0]        m_axi_awid,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [AXI_ID_W-1:0]        m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CNT_W  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [IDX_W-1:0]   next_ptr;
  logic               unused_bid;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Only one transaction is ever outstanding, so bid carries no information.
  assign unused_bid = ^{m_axi_bid, arb_grant};

  assign next_ptr = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  assign m_axi_awid    = AXI_ID_W'(AXI_ID);
  assign m_axi_awaddr  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFF);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_AWCACHE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = (state_q == ST_XFER) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == ST_XFER) && !w_done_q;
  assign m_axi_wlast   = m_axi_wvalid;
  assign m_axi_bready  = (state_q == ST_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      retry_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      retry_q   <= retry_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    retry_d   = retry_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = '0;
    req_err   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          addr_d    = req_addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[arb_idx*DATA_W +: DATA_W];
          wstrb_d   = req_wstrb[arb_idx*STRB_W +: STRB_W];
          grant_d   = arb_idx;
          retry_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY && retry_q < CNT_W'(RETRY_MAX)) begin
            // Replay the same captured beat on both channels.
            retry_d   = retry_q + 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_XFER;
          end else begin
            req_ready[grant_q] = 1'b1;
            req_err[grant_q]   = (m_axi_bresp != AXI_RESP_OKAY);
            rr_ptr_d           = next_ptr;
            state_d            = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter with two requesters.
module tb_axi_write_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready;
  logic [1:0]  req_err;
  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [0:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  int total;
  int bad;
  int awHs;
  int awBase;

  axi_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awlock  (m_axi_awlock),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awqos   (m_axi_awqos),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bid     (m_axi_bid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts completed AW handshakes so replays can be tallied.
  initial awHs = 0;
  always @(posedge clk) begin
    if (!reset && m_axi_awvalid && m_axi_awready) awHs++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic awr, input logic wr,
                               input logic bv, input logic [1:0] br);
    req_valid     = valid;
    m_axi_awready = awr;
    m_axi_wready  = wr;
    m_axi_bvalid  = bv;
    m_axi_bresp   = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bid     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_awvalid", 64'(m_axi_awvalid), 64'h0);
    checkOutput("rst_wvalid", 64'(m_axi_wvalid), 64'h0);
    checkOutput("rst_bready", 64'(m_axi_bready), 64'h0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_req_err", 64'(req_err), 64'h0);
    checkOutput("rst_awaddr", 64'(m_axi_awaddr), 64'h0);
    reset = 1'b0;

    // Single write with minimum latency
    req_addr[31:0]  = 32'h0000_1004;
    req_wdata[31:0] = 32'hDEAD_BEEF;
    req_wstrb[3:0]  = 4'hF;
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 2'b00);
    checkOutput("t1_c0_awvalid", 64'(m_axi_awvalid), 64'h0);
    tick();
    checkOutput("t1_c1_awvalid", 64'(m_axi_awvalid), 64'h1);
    checkOutput("t1_c1_wvalid", 64'(m_axi_wvalid), 64'h1);
    checkOutput("t1_c1_wlast", 64'(m_axi_wlast), 64'h1);
    checkOutput("t1_c1_awaddr", 64'(m_axi_awaddr), 64'h1004);
    checkOutput("t1_c1_wdata", 64'(m_axi_wdata), 64'hDEAD_BEEF);
    checkOutput("t1_c1_wstrb", 64'(m_axi_wstrb), 64'hF);
    checkOutput("t1_awid", 64'(m_axi_awid), 64'h0);
    checkOutput("t1_awlen", 64'(m_axi_awlen), 64'h0);
    checkOutput("t1_awsize", 64'(m_axi_awsize), 64'h2);
    checkOutput("t1_awburst", 64'(m_axi_awburst), 64'h1);
    checkOutput("t1_awlock", 64'(m_axi_awlock), 64'h0);
    checkOutput("t1_awcache", 64'(m_axi_awcache), 64'h3);
    checkOutput("t1_awprot", 64'(m_axi_awprot), 64'h0);
    checkOutput("t1_awqos", 64'(m_axi_awqos), 64'h0);
    checkOutput("t1_c1_bready", 64'(m_axi_bready), 64'h0);
    checkOutput("t1_c1_req_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("t1_c2_bready", 64'(m_axi_bready), 64'h1);
    checkOutput("t1_c2_req_ready", 64'(req_ready), 64'h1);
    checkOutput("t1_c2_req_err", 64'(req_err), 64'h0);
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    checkOutput("t1_c3_req_ready", 64'(req_ready), 64'h0);
    checkOutput("t1_c3_awvalid", 64'(m_axi_awvalid), 64'h0);

    // Contention from a fresh pointer: grants must alternate 0,1,0,1,...
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req_addr  = {32'h0000_3000, 32'h0000_2000};
    req_wdata = {32'h3333_3333, 32'h2222_2222};
    req_wstrb = 8'hFF;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 2'b00);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("cont%0d_awaddr", k), 64'(m_axi_awaddr),
                  (k % 2 == 1) ? 64'h3000 : 64'h2000);
      tick();
      checkOutput($sformatf("cont%0d_ready", k), 64'(req_ready),
                  (k % 2 == 1) ? 64'h2 : 64'h1);
      tick();
    end

    // Channel skew: W accepted at cycle 1, AW only at cycle 5; unaligned address
    req_addr[31:0]  = 32'h0000_400B;
    req_wdata[31:0] = 32'h1234_5678;
    req_wstrb[3:0]  = 4'h3;
    applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("skew_c1_awvalid", 64'(m_axi_awvalid), 64'h1);
    checkOutput("skew_c1_wvalid", 64'(m_axi_wvalid), 64'h1);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("skew_c2_wvalid", 64'(m_axi_wvalid), 64'h0);
    checkOutput("skew_c2_awvalid", 64'(m_axi_awvalid), 64'h1);
    tick();
    checkOutput("skew_c3_awvalid", 64'(m_axi_awvalid), 64'h1);
    tick();
    checkOutput("skew_c4_awvalid", 64'(m_axi_awvalid), 64'h1);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("skew_c5_awvalid", 64'(m_axi_awvalid), 64'h1);
    checkOutput("skew_c5_awaddr", 64'(m_axi_awaddr), 64'h4008);
    checkOutput("skew_c5_bready", 64'(m_axi_bready), 64'h0);
    tick();
    checkOutput("skew_c6_bready", 64'(m_axi_bready), 64'h1);
    checkOutput("skew_c6_awvalid", 64'(m_axi_awvalid), 64'h0);
    checkOutput("skew_c6_wdata", 64'(m_axi_wdata), 64'h1234_5678);
    checkOutput("skew_c6_wstrb", 64'(m_axi_wstrb), 64'h3);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("skew_c6_req_ready", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

    // Error retry: SLVERR twice then OKAY on requester 1
    awBase = awHs;
    req_addr[63:32]  = 32'h0000_5000;
    req_wdata[63:32] = 32'hA5A5_A5A5;
    req_wstrb[7:4]   = 4'hF;
    applyStimulus(2'b10, 1'b1, 1'b1, 1'b1, 2'b10);
    tick();
    req_addr[63:32]  = 32'hFFFF_FFF0;
    req_wdata[63:32] = 32'h0;
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    for (int a = 0; a < 3; a++) begin
      checkOutput($sformatf("retry%0d_awaddr", a), 64'(m_axi_awaddr), 64'h5000);
      checkOutput($sformatf("retry%0d_wdata", a), 64'(m_axi_wdata), 64'hA5A5_A5A5);
      tick();
      applyStimulus(2'b00, 1'b1, 1'b1, 1'b1, (a == 2) ? 2'b00 : 2'b10);
      checkOutput($sformatf("retry%0d_ready", a), 64'(req_ready), (a == 2) ? 64'h2 : 64'h0);
      checkOutput($sformatf("retry%0d_err", a), 64'(req_err), 64'h0);
      tick();
    end
    checkOutput("retry_aw_count", 64'(awHs - awBase), 64'd3);
    checkOutput("retry_idle_ready", 64'(req_ready), 64'h0);

    // Retry exhaustion: SLVERR forever on requester 0
    awBase = awHs;
    req_addr[31:0]  = 32'h0000_6000;
    req_wdata[31:0] = 32'h0BAD_F00D;
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 2'b10);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    for (int a = 0; a < 4; a++) begin
      tick();
      checkOutput($sformatf("exh%0d_ready", a), 64'(req_ready), (a == 3) ? 64'h1 : 64'h0);
      checkOutput($sformatf("exh%0d_err", a), 64'(req_err), (a == 3) ? 64'h1 : 64'h0);
      tick();
    end
    checkOutput("exh_aw_count", 64'(awHs - awBase), 64'd4);
    checkOutput("exh_idle_err", 64'(req_err), 64'h0);

    // Asynchronous reset mid-transfer, then pointer must restart at 0
    req_addr[63:32] = 32'h0000_7000;
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("rxf_awvalid_before", 64'(m_axi_awvalid), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rxf_awvalid", 64'(m_axi_awvalid), 64'h0);
    checkOutput("rxf_wvalid", 64'(m_axi_wvalid), 64'h0);
    checkOutput("rxf_bready", 64'(m_axi_bready), 64'h0);
    reset = 1'b0;
    req_addr[31:0] = 32'h0000_8000;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    checkOutput("rxf_restart_awaddr", 64'(m_axi_awaddr), 64'h8000);
    tick();
    checkOutput("rxf_restart_ready", 64'(req_ready), 64'h1);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
Shares one AXI4 write master port between N_REQ cache write channels, e.g. I-cache and D-cache write-through buffers, or several cache instances in a multi-core build. Each requester issues single-beat IOb-style writes (valid/addr/wdata/wstrb, ready). The block grants requesters round-robin and sequences the AW, W and B phases. On an error response it replays the captured beat, up to a retry limit.

Parameters:
N_REQ, 2, number of requesters (>=2)
ADDR_W, 32, byte-address width, requester side and AXI side
DATA_W, 32, data width, requester side and AXI side; 32/64/128
AXI_ID_W, 1, AXI ID width
AXI_ID, 0, constant value driven on awid
RETRY_MAX, 3, replays allowed after a non-OKAY bresp before error is reported

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  flattened write data
req_wstrb  in  N_REQ*DATA_W/8  flattened byte strobes
req_ready  out  N_REQ  one-cycle completion pulse to requester i
req_err  out  N_REQ  one-cycle pulse with req_ready: retries exhausted
m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  out  AXI4 widths  AW channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA_W, DATA_W/8, 1, 1  W channel
m_axi_wready  in  1
m_axi_bid  in  AXI_ID_W
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Constant AW fields: awid=AXI_ID, awlen=0, awsize=log2(DATA_W/8), awburst=2'b01, awlock=0, awcache=4'b0011, awprot=0, awqos=0. wlast=wvalid.
- awaddr = captured address with the low log2(DATA_W/8) bits forced to 0.
- Reset values: state IDLE; awvalid, wvalid, bready, req_ready and req_err all 0. rr_ptr=0, retry_cnt=0, capture registers 0.
- Reset mid-transfer abandons the transaction. No replay after reset.
- IDLE:
  - If any req_valid is high, grant the first asserted requester at or after rr_ptr, searching upward with wrap-around.
  - Register addr/wdata/wstrb and the grant index; set aw_done=w_done=0 and retry_cnt=0; go to XFER.
- XFER:
  - awvalid=!aw_done and wvalid=!w_done, asserted together.
  - awready sets aw_done; wready sets w_done. Both may occur in the same cycle, in either order.
  - When both are done (including in the same cycle) go to RESP.
  - awvalid/wvalid never drop before their ready (AXI stability rule). Outputs come from registers.
- RESP: bready=1.
  - bvalid and bresp==2'b00: req_ready[grant]=1 this cycle; rr_ptr <= grant+1 mod N_REQ; go to IDLE.
  - bvalid and bresp!=0 and retry_cnt<RETRY_MAX: retry_cnt++; clear aw_done/w_done; go to XFER with the same captured beat.
  - bvalid and bresp!=0 and retry_cnt==RETRY_MAX: req_ready[grant]=1 and req_err[grant]=1 this cycle; advance rr_ptr; go to IDLE.
  - bid is ignored; only one transaction is ever outstanding.
- Minimum latency: valid seen in IDLE at cycle 0, AW/W handshake at cycle 1, B at cycle 2, so req_ready is at cycle 2. The next grant is evaluated at cycle 3.
- Requester inputs are ignored after capture. A requester may deassert valid before it is granted.
- Non-granted requesters see req_ready=0. At most one bit of req_ready is high at any time.

Decomposition:
- Shared package (iob_cache_axi_pkg):
  - AXI resp encodings (OKAY=2'b00).
  - Burst INCR and the awcache constant.
  - State encoding: IDLE=0, XFER=1, RESP=2.
- Sub-module rr_arbiter: purely combinational. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and a binary index. It is reusable by a future read-channel arbiter.

Test Plan:
- Single write: req0 addr 0x1004, wdata 0xDEADBEEF, wstrb 0xF; awready=wready=bvalid=1 immediately, bresp=0 -> awaddr 0x1004, wdata matches, req_ready[0] pulses exactly at cycle 2, req_err=0.
- Contention: req0 and req1 both valid continuously, 4 writes each -> grants alternate 0,1,0,1,…; no requester is granted twice in a row while the other waits.
- Channel skew: wready at cycle 1, awready held low until cycle 5 -> wvalid drops after cycle 1, awvalid holds until cycle 5, RESP is entered at cycle 6, data is unchanged.
- Error retry: bresp=2'b10 twice, then OKAY -> two replays of the identical beat (3 AW handshakes total); req_ready once, req_err=0.
- Retry exhaustion: bresp=2'b10 always, RETRY_MAX=3 -> 4 AW handshakes, then req_ready and req_err pulse together for the granted requester.
- Reset during XFER with awvalid high -> all AXI valids and bready go 0 immediately (async); next request restarts cleanly from rr_ptr=0.
